// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// The starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
package imem_dmem_arbiter_pkg;

  localparam int WORD_WIDTH               = 32;
  localparam int ARB_STARVE_LIMIT_DEFAULT = 4;
  localparam int STARVE_CNT_W             = 4;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  // Byte address to zero-extended word address.
  function automatic logic [WORD_WIDTH-1:0] word_addr(
    input logic [WORD_WIDTH-1:0] byte_addr
  );
    return {2'b00, byte_addr[WORD_WIDTH-1:2]};
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
// Saturating count of cycles fetch waits while requesting.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LIM) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter: data side has priority, fetch optionally
// protected from starvation when ARB_STARVE_GUARD_EN is defined.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int W            = WORD_WIDTH,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req,
  input  logic [W-1:0] i_addr,
  output logic         i_gnt,
  output logic         i_rvalid,
  output logic [W-1:0] i_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [3:0]   d_be,
  input  logic [W-1:0] d_addr,
  input  logic [W-1:0] d_wdata,
  output logic         d_gnt,
  output logic         d_rvalid,
  output logic [W-1:0] d_rdata,
`ifdef ARB_STARVE_GUARD_EN
  output logic         starve_hit,
`endif
  output logic         mem_en,
  output logic         mem_we,
  output logic [3:0]   mem_be,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata
);

  logic   w_force_i;
  logic   w_gnt_i;
  logic   w_gnt_d;
  owner_e r_owner;

`ifdef ARB_STARVE_GUARD_EN
  logic w_at_limit;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_gnt      (w_gnt_i),
    .o_at_limit (w_at_limit)
  );

  assign w_force_i  = w_at_limit & i_req & d_req;
  assign starve_hit = w_force_i & ~rst;
`else
  assign w_force_i = 1'b0;
`endif

  // Grants are held low while reset is asserted.
  assign w_gnt_d = ~rst & d_req & ~w_force_i;
  assign w_gnt_i = ~rst & i_req & (~d_req | w_force_i);

  assign i_gnt  = w_gnt_i;
  assign d_gnt  = w_gnt_d;
  assign mem_en = w_gnt_i | w_gnt_d;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_addr  = '0;
    mem_wdata = d_wdata;
    unique case (1'b1)
      w_gnt_d: begin
        mem_we   = d_we;
        mem_be   = d_be;
        mem_addr = W'(word_addr(WORD_WIDTH'(d_addr)));
      end
      w_gnt_i: begin
        mem_addr = W'(word_addr(WORD_WIDTH'(i_addr)));
      end
      default: ;
    endcase
  end

  // Stores complete on grant, so only reads claim the response slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWNER_NONE;
    end else if (w_gnt_d && !d_we) begin
      r_owner <= OWNER_D;
    end else if (w_gnt_i) begin
      r_owner <= OWNER_I;
    end else begin
      r_owner <= OWNER_NONE;
    end
  end

  assign i_rvalid = (r_owner == OWNER_I);
  assign d_rvalid = (r_owner == OWNER_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter with a small unified memory.
// Contention expectations follow ARB_STARVE_GUARD_EN when defined.
module tb_imem_dmem_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_gnt;
  logic         i_rvalid;
  logic [W-1:0] i_rdata;
  logic         d_req;
  logic         d_we;
  logic [3:0]   d_be;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_gnt;
  logic         d_rvalid;
  logic [W-1:0] d_rdata;
  logic         mem_en;
  logic         mem_we;
  logic [3:0]   mem_be;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
`ifdef ARB_STARVE_GUARD_EN
  logic         starve_hit;
`endif

  imem_dmem_arbiter #(.W(W), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
`ifdef ARB_STARVE_GUARD_EN
    .starve_hit(starve_hit),
`endif
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:0]];
      end
    end
  end

  typedef struct {
    logic        own_i;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // Monitor: pops an expected response whenever a valid is presented.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot", 32'(i_gnt & d_gnt), 32'd0);
      if (i_rvalid || d_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rv_owner", {30'd0, i_rvalid, d_rvalid},
              e.own_i ? 32'd2 : 32'd1);
          chk("rdata", e.own_i ? i_rdata : d_rdata, e.data);
        end
      end
    end
  end

  // Checks one arbitration cycle at the negedge, then moves past the posedge.
  task automatic cyc(input string n, input logic gi, input logic gd,
                     input logic [31:0] maddr, input logic we,
                     input logic [3:0] be, input logic [31:0] wd,
                     input logic sh, input logic [31:0] rexp);
    @(negedge clk);
    chk({n, "_i_gnt"}, 32'(i_gnt), 32'(gi));
    chk({n, "_d_gnt"}, 32'(d_gnt), 32'(gd));
    chk({n, "_mem_en"}, 32'(mem_en), 32'(gi | gd));
`ifdef ARB_STARVE_GUARD_EN
    chk({n, "_starve_hit"}, 32'(starve_hit), 32'(sh));
`endif
    if (gi || gd) begin
      chk({n, "_mem_addr"}, mem_addr, maddr);
      chk({n, "_mem_we"}, 32'(mem_we), 32'(we));
      chk({n, "_mem_be"}, 32'(mem_be), 32'(be));
      if (we) chk({n, "_mem_wdata"}, mem_wdata, wd);
    end
    if (gi || (gd && !we)) sb.push_back('{gi, rexp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic gi_exp;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[2] = 32'h24020005;
    mem[4] = 32'h11223344;
    mem[8] = 32'hDEADBEEF;
    mem_rdata = '0;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
    d_addr = 32'h20; d_wdata = '0;
    #2;
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    #10 rst = 1'b0;
    @(posedge clk); #1;

    cyc("idle", 0, 0, 0, 0, 4'hF, 0, 0, 0);

    i_req = 1'b1; i_addr = 32'h8;
    cyc("fetch", 1, 0, 32'd2, 0, 4'hF, 0, 0, 32'h24020005);
    i_req = 1'b0;

    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
    d_addr = 32'h10; d_wdata = 32'hAABBCCDD;
    cyc("store", 0, 1, 32'd4, 1, 4'b0011, 32'hAABBCCDD, 0, 0);

    d_we = 1'b0; d_be = 4'hF;
    cyc("load_st", 0, 1, 32'd4, 0, 4'hF, 0, 0, 32'h1122CCDD);

    i_req = 1'b1; i_addr = 32'h8; d_addr = 32'h20;
    cyc("both", 0, 1, 32'd8, 0, 4'hF, 0, 0, 32'hDEADBEEF);
    d_req = 1'b0;
    cyc("i_after", 1, 0, 32'd2, 0, 4'hF, 0, 0, 32'h24020005);

    i_addr = 32'h23;
    cyc("b2b0", 1, 0, 32'd8, 0, 4'hF, 0, 0, 32'hDEADBEEF);
    i_addr = 32'h10;
    cyc("b2b1", 1, 0, 32'd4, 0, 4'hF, 0, 0, 32'h1122CCDD);

    d_req = 1'b1; i_addr = 32'h8;
    cyc("drop0", 0, 1, 32'd8, 0, 4'hF, 0, 0, 32'hDEADBEEF);
    i_req = 1'b0; d_req = 1'b0;
    cyc("drop1", 0, 0, 0, 0, 4'hF, 0, 0, 0);

    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      gi_exp = (k == 4);
`else
      gi_exp = 1'b0;
`endif
      cyc($sformatf("cont%0d", k), gi_exp, ~gi_exp,
          gi_exp ? 32'd2 : 32'd8, 0, 4'hF, 0, gi_exp,
          gi_exp ? 32'h24020005 : 32'hDEADBEEF);
    end
    i_req = 1'b0; d_req = 1'b0;
    cyc("idle2", 0, 0, 0, 0, 4'hF, 0, 0, 0);
    cyc("idle3", 0, 0, 0, 0, 4'hF, 0, 0, 0);

    i_req = 1'b1; i_addr = 32'h8;
    cyc("rst_rd", 1, 0, 32'd2, 0, 4'hF, 0, 0, 32'h24020005);
    i_req = 1'b0;
    chk("rv_before_rst", 32'(i_rvalid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("async_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    sb.delete();
    @(posedge clk); #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares one single-port, word-addressed, synchronous-read memory between the instruction-fetch requester (I) and the load/store requester (D). Issues at most one memory access per cycle and routes each read response back to its owner one cycle later. Sits between the IF/MEM pipeline stages and the unified memory in simulation and FPGA builds. Data side has fixed priority; an optional starvation guard protects fetch.

Parameters:
W, `WORD_WIDTH (32), data and address width
STARVE_LIMIT, 4, consecutive cycles I may be denied while requesting before it is forced to win (guard builds only); legal range 1..15

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
i_req  in  1  fetch request, level, held until granted
i_addr  in  W  fetch byte address; bits [1:0] ignored
i_gnt  out  1  fetch accepted this cycle (combinational)
i_rvalid  out  1  fetch data valid (registered)
i_rdata  out  W  fetch data
d_req  in  1  load/store request, level, held until granted
d_we  in  1  1 = store
d_be  in  4  byte enables for stores
d_addr  in  W  data byte address; bits [1:0] ignored
d_wdata  in  W  store data
d_gnt  out  1  data accepted this cycle (combinational)
d_rvalid  out  1  load data valid (registered)
d_rdata  out  W  load data
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write
mem_be  out  4  memory byte enables
mem_addr  out  W  word address (byte address >> 2)
mem_wdata  out  W  memory write data
mem_rdata  in  W  memory read data, valid one cycle after a read with mem_en=1

Behaviour:
- Reset: i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, resp_owner=NONE, starve_cnt=0, mem_en=0. Reset mid-transaction drops the outstanding response; no rvalid is issued for it.
- Arbitration each cycle (combinational): d_req only -> D; i_req only -> I; both -> D, unless the guard forces I; neither -> mem_en=0, no grant.
- Granted side drives mem_*: mem_we=d_we&D, mem_be=D ? d_be : 4'hF, mem_addr=addr[W-1:2] zero-extended.
- Exactly one of i_gnt/d_gnt may be high in a cycle; never both.
- Response pipeline: on posedge, resp_owner <= I for an I grant, D for a D read grant, NONE otherwise (including stores). i_rvalid = (resp_owner==I); d_rvalid = (resp_owner==D); both rdata outputs = mem_rdata. Latency is exactly 1 cycle, fully pipelined, back-to-back grants allowed.
- Stores produce no rvalid; d_gnt is their completion.
- A requester whose req drops before a grant is simply not served; no state is retained.
- States (resp_owner): NONE, I, D; transitions as above every cycle, with no stall input.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined: 4-bit starve_cnt increments each cycle i_req=1 and i_gnt=0, saturating at STARVE_LIMIT. It clears on i_gnt or on i_req=0. When starve_cnt==STARVE_LIMIT and both requests are present, I wins. Output port starve_hit (1 bit) pulses on each forced grant.
- Undefined: strict D priority; no counter; starve_hit is absent.

Decomposition:
- defines.v gains OWNER_NONE=2'd0, OWNER_I=2'd1, OWNER_D=2'd2 and ARB_STARVE_LIMIT_DEFAULT.
- One sub-module: arb_starve_ctr (saturating counter plus compare), instantiated only under ARB_STARVE_GUARD_EN.

Test Plan:
- i_req=1, i_addr=0x00000008, memory word 2 = 0x24020005 -> same cycle: i_gnt=1, mem_addr=2; next cycle: i_rvalid=1, i_rdata=0x24020005.
- d_req=1, d_we=1, d_be=4'b0011, d_addr=0x10, d_wdata=0xAABBCCDD -> mem_we=1, mem_be=0011, mem_addr=4, d_gnt=1. No d_rvalid follows. A later read of 0x10 returns the low half updated.
- i_req and d_req (load at 0x20) held together for 1 cycle -> d_gnt=1, i_gnt=0. Next cycle: d_rvalid=1, and i_gnt=1 if d_req has dropped.
- Guard on, STARVE_LIMIT=4, both requests held continuously -> d_gnt for 4 cycles, then i_gnt=1 with starve_hit=1 on cycle 5, then D again. Guard off: i_gnt stays 0 throughout.
- Read granted, then rst asserted asynchronously before the next edge -> i_rvalid/d_rvalid=0 immediately and remain 0 after release with no requests.
